line_window: RTL

Pixel-stream reader that sits downstream of the edge-detect line buffers and turns a raster-order grayscale pixel stream into 3x3 pixel windows for the Sobel kernel. It keeps two full-line delays plus a 3x3 register window and tracks row and column position. It emits one window per accepted pixel once the window lies fully inside the image. Windows are emitted through a valid/ready handshake with backpressure to the pixel source.

---
 rtl/line_window_pkg.sv | 11 +
 rtl/line_window_if.sv | 28 ++
 rtl/line_window_line_delay.sv | 47 ++++
 rtl/line_window.sv | 113 +++++++++++
 4 files changed

// File: rtl/line_window_pkg.sv
// Shared types and constants for the edge-detect pixel pipeline.
package edge_detect_pkg;

  localparam int PIXEL_WIDTH = 8;
  localparam int WIN_SIZE    = 3;
  localparam int WIN_PIXELS  = WIN_SIZE * WIN_SIZE;

  typedef logic [PIXEL_WIDTH-1:0] pixel_t;
  typedef pixel_t [WIN_PIXELS-1:0] window_t;

endpackage

// File: rtl/line_window_if.sv
// Pixel-in / window-out handshake bundle for line_window.
interface line_window_if
  import edge_detect_pkg::*;
#(
  parameter int PIXEL_WIDTH = edge_detect_pkg::PIXEL_WIDTH
);

  logic [PIXEL_WIDTH-1:0]            in_data;
  logic                              in_valid;
  logic                              in_ready;
  logic [WIN_PIXELS*PIXEL_WIDTH-1:0] win_data;
  logic                              win_valid;
  logic                              win_ready;
  logic                              win_last;

  // Pixel source and window consumer side
  modport master (
    output in_data, in_valid, win_ready,
    input  in_ready, win_data, win_valid, win_last
  );

  // line_window side
  modport slave (
    input  in_data, in_valid, win_ready,
    output in_ready, win_data, win_valid, win_last
  );

endinterface

// File: rtl/line_window_line_delay.sv
// Enable-gated fixed-length delay line: data_o is the sample written DEPTH
// enabled cycles ago. Circular buffer; contents are intentionally never cleared.
module line_delay #(
  parameter int DEPTH = 720,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    ptr_q, ptr_d;

  // Oldest entry sits at the write pointer and is read before being replaced
  assign data_o = mem_q[ptr_q];

  // Pointer advance with wrap
  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
    end
  end

  // Pointer register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Storage write, no reset
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      mem_q[ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/line_window.sv
// Raster pixel stream to 3x3 window converter with valid/ready backpressure.
// Window index 0 is top-left, 8 is bottom-right (newest pixel).
module line_window
  import edge_detect_pkg::*;
#(
  parameter int IMG_WIDTH   = 720,
  parameter int IMG_HEIGHT  = 540,
  parameter int PIXEL_WIDTH = edge_detect_pkg::PIXEL_WIDTH
) (
  input  logic          clock,
  input  logic          reset,
  line_window_if.slave  bus
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_WIN0 = CW'(WIN_SIZE - 1);
  localparam logic [RW-1:0] ROW_WIN0 = RW'(WIN_SIZE - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [WIN_PIXELS-1:0][PIXEL_WIDTH-1:0] win_q, win_d;
  logic valid_q, valid_d;
  logic last_q, last_d;

  logic accept;
  logic emit;
  logic at_last;
  logic [PIXEL_WIDTH-1:0] ld0_out, ld1_out;

  assign bus.in_ready  = !valid_q || bus.win_ready;
  assign accept        = bus.in_valid && bus.in_ready;
  assign emit          = (row_q >= ROW_WIN0) && (col_q >= COL_WIN0);
  assign at_last       = (row_q == ROW_LAST) && (col_q == COL_LAST);

  assign bus.win_data  = win_q;
  assign bus.win_valid = valid_q;
  assign bus.win_last  = last_q;

  line_delay #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PIXEL_WIDTH)
  ) u_delay0 (
    .clk_i  (clock),
    .rst_ni (reset),
    .en_i   (accept),
    .data_i (bus.in_data),
    .data_o (ld0_out)
  );

  line_delay #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PIXEL_WIDTH)
  ) u_delay1 (
    .clk_i  (clock),
    .rst_ni (reset),
    .en_i   (accept),
    .data_i (ld0_out),
    .data_o (ld1_out)
  );

  // Position counters, window shift and output handshake next-state
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      // Each row shifts left; the newest column enters on the right
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = ld1_out;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = ld0_out;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = bus.in_data;
      valid_d  = emit;
      last_d   = at_last;
    end else if (bus.win_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

endmodule
